// File: rtl/ysyx_22040383_pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
// State encoding, default widths and the control bundle type.
package ysyx_22040383_pipe_ctrl_pkg;

  localparam int RA_W_DEF    = 5;
  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W_DEF   = 32;
  localparam int WCNT_W      = 8;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic flush_id;
    logic flush_ex;
    logic bubble_wb;
  } ctrl_t;

endpackage

// File: rtl/ysyx_22040383_hazard_det.sv
// Load-use hazard detector between the ID and EX stages.
// A load writing x0 never creates a hazard.
module ysyx_22040383_hazard_det
  import ysyx_22040383_pipe_ctrl_pkg::*;
#(
  parameter int RA_W = RA_W_DEF
) (
  input  logic [RA_W-1:0] id_rs1,
  input  logic            id_rs1_used,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_rs2_used,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_is_load,
  input  logic            ex_valid,
  output logic            loaduse
);

  logic rd_live;
  logic rs1_hit;
  logic rs2_hit;

  // A real load in EX targeting a nonzero register, read by ID
  always_comb begin
    rd_live = ex_valid & ex_is_load
            & (ex_rd != '0);
    rs1_hit = id_rs1_used
            & (id_rs1 == ex_rd);
    rs2_hit = id_rs2_used
            & (id_rs2 == ex_rd);
    loaduse = rd_live
            & (rs1_hit | rs2_hit);
  end

endmodule

// File: rtl/ysyx_22040383_pipe_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline.
// Memory waits, redirects, load-use and fetch starvation, fixed priority.
module ysyx_22040383_pipe_ctrl
  import ysyx_22040383_pipe_ctrl_pkg::*;
#(
  parameter int RA_W    = RA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic             id_rs1_used,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_rs2_used,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_valid,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             ex_redirect,
  input  logic             ifu_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             bubble_wb,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [WCNT_W-1:0] TMO_LAST =
    WCNT_W'(TIMEOUT - 1);

  state_e            state_q;
  logic [WCNT_W-1:0] wait_cnt_q;
  logic              mem_timeout_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic  loaduse;
  logic  memwait;
  ctrl_t ctrl;

  ysyx_22040383_hazard_det #(
    .RA_W (RA_W)
  ) u_hazard_det (
    .id_rs1      (id_rs1),
    .id_rs1_used (id_rs1_used),
    .id_rs2      (id_rs2),
    .id_rs2_used (id_rs2_used),
    .ex_rd       (ex_rd),
    .ex_is_load  (ex_is_load),
    .ex_valid    (ex_valid),
    .loaduse     (loaduse)
  );

  // Whole pipe frozen: new miss, ongoing miss, or watchdog tripped
  always_comb begin
    memwait = 1'b0;
    unique case (state_q)
      RUN:      memwait = mem_req & ~mem_ack;
      MEM_WAIT: memwait = ~mem_ack;
      ERR:      memwait = 1'b1;
      default:  memwait = 1'b1;
    endcase
  end

  // Fixed-priority control decode; reset floods the pipe with bubbles
  always_comb begin
    ctrl = '0;
    priority case (1'b1)
      !sys_rst: begin
        ctrl.flush_id  = 1'b1;
        ctrl.flush_ex  = 1'b1;
        ctrl.bubble_wb = 1'b1;
      end
      memwait: begin
        ctrl.stall_if  = 1'b1;
        ctrl.stall_id  = 1'b1;
        ctrl.stall_ex  = 1'b1;
        ctrl.stall_mem = 1'b1;
        ctrl.bubble_wb = 1'b1;
      end
      ex_redirect: begin
        ctrl.flush_id = 1'b1;
        ctrl.flush_ex = 1'b1;
      end
      loaduse: begin
        ctrl.stall_if = 1'b1;
        ctrl.stall_id = 1'b1;
        ctrl.flush_ex = 1'b1;
      end
      !ifu_ready: begin
        ctrl.stall_if = 1'b1;
        ctrl.flush_id = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  // Memory-wait FSM with watchdog; ERR holds until reset
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (mem_req && !mem_ack) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= '0;
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            state_q <= RUN;
          end else if (wait_cnt_q == TMO_LAST) begin
            state_q       <= ERR;
            mem_timeout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        ERR: begin
          mem_timeout_q <= 1'b1;
        end
        default: begin
          state_q       <= ERR;
          mem_timeout_q <= 1'b1;
        end
      endcase
    end
  end

  // Saturating count of cycles with fetch held
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      stall_cnt_q <= '0;
    end else if (ctrl.stall_if && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_if    = ctrl.stall_if;
  assign stall_id    = ctrl.stall_id;
  assign stall_ex    = ctrl.stall_ex;
  assign stall_mem   = ctrl.stall_mem;
  assign flush_id    = ctrl.flush_id;
  assign flush_ex    = ctrl.flush_ex;
  assign bubble_wb   = ctrl.bubble_wb;
  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_ysyx_22040383_pipe_ctrl.sv
// Self-checking bench for the pipeline stall/flush sequencer.
// Two instances: default parameters, and TIMEOUT=4 / CNT_W=4.
module tb_ysyx_22040383_pipe_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] rs1, rs2, exrd;
  logic       rs1u, rs2u, ld, exv;
  logic       req, ack, redir, ifu;

  logic [1:0] sif, sid, sex, smem;
  logic [1:0] fid, fex, bwb, tmo;
  logic [31:0] cnt0;
  logic [3:0]  cnt1;

  ysyx_22040383_pipe_ctrl dut0 (
    .sys_clk(clk), .sys_rst(rst),
    .id_rs1(rs1), .id_rs1_used(rs1u),
    .id_rs2(rs2), .id_rs2_used(rs2u),
    .ex_rd(exrd), .ex_is_load(ld),
    .ex_valid(exv), .mem_req(req),
    .mem_ack(ack), .ex_redirect(redir),
    .ifu_ready(ifu),
    .stall_if(sif[0]), .stall_id(sid[0]),
    .stall_ex(sex[0]), .stall_mem(smem[0]),
    .flush_id(fid[0]), .flush_ex(fex[0]),
    .bubble_wb(bwb[0]), .mem_timeout(tmo[0]),
    .stall_cnt(cnt0)
  );

  ysyx_22040383_pipe_ctrl #(
    .TIMEOUT(4), .CNT_W(4)
  ) dut1 (
    .sys_clk(clk), .sys_rst(rst),
    .id_rs1(rs1), .id_rs1_used(rs1u),
    .id_rs2(rs2), .id_rs2_used(rs2u),
    .ex_rd(exrd), .ex_is_load(ld),
    .ex_valid(exv), .mem_req(req),
    .mem_ack(ack), .ex_redirect(redir),
    .ifu_ready(ifu),
    .stall_if(sif[1]), .stall_id(sid[1]),
    .stall_ex(sex[1]), .stall_mem(smem[1]),
    .flush_id(fid[1]), .flush_ex(fex[1]),
    .bubble_wb(bwb[1]), .mem_timeout(tmo[1]),
    .stall_cnt(cnt1)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic       rs1u;
    logic [4:0] rs2;
    logic       rs2u;
    logic [4:0] exrd;
    logic       ld, exv, req, ack, redir, ifu;
  } in_t;

  typedef struct packed {
    in_t        i;
    logic [7:0] e;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  bit     mw[2];
  bit     me[2];
  int     nw[2];
  longint mcnt[2];
  int     tmo_p[2] = '{255, 4};
  longint cmax[2]  = '{64'hFFFF_FFFF, 15};

  function automatic logic [7:0] outs(int i);
    return {sif[i], sid[i], sex[i], smem[i],
            fid[i], fex[i], bwb[i], tmo[i]};
  endfunction

  function automatic in_t idle();
    in_t v = '0;
    v.rst = 1'b1;
    v.ifu = 1'b1;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] a,
                     input logic [63:0] x);
    n_chk++;
    if (a !== x) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               nm, a, x);
    end
  endtask

  task automatic drive(input in_t v);
    rst   = v.rst;
    rs1   = v.rs1;  rs1u = v.rs1u;
    rs2   = v.rs2;  rs2u = v.rs2u;
    exrd  = v.exrd; ld   = v.ld;
    exv   = v.exv;  req  = v.req;
    ack   = v.ack;  redir = v.redir;
    ifu   = v.ifu;
  endtask

  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      mw[i] = 0; me[i] = 0;
      nw[i] = 0; mcnt[i] = 0;
    end
  endtask

  // expected outputs from the priority rules
  function automatic logic [7:0] mexp(int i, in_t v);
    bit lu;
    if (!v.rst) return 8'b0000_1110;
    lu = v.exv && v.ld && (v.exrd != 0) &&
         ((v.rs1u && v.rs1 == v.exrd) ||
          (v.rs2u && v.rs2 == v.exrd));
    if (me[i] || (!v.ack && (mw[i] || v.req)))
      return {7'b1111001, me[i]};
    if (v.redir) return 8'b0000_1100;
    if (lu)      return 8'b1100_0100;
    if (!v.ifu)  return 8'b1000_1000;
    return 8'b0;
  endfunction

  task automatic mtick(input in_t v,
                       input logic [7:0] e0,
                       input logic [7:0] e1);
    logic sf[2];
    sf[0] = e0[7];
    sf[1] = e1[7];
    for (int i = 0; i < 2; i++) begin
      if (!v.rst) continue;
      if (sf[i] && mcnt[i] < cmax[i]) mcnt[i]++;
      if (me[i]) begin
      end else if (mw[i]) begin
        if (v.ack) mw[i] = 0;
        else begin
          nw[i]++;
          if (nw[i] == tmo_p[i]) begin
            mw[i] = 0;
            me[i] = 1;
          end
        end
      end else if (v.req && !v.ack) begin
        mw[i] = 1;
        nw[i] = 0;
      end
    end
  endtask

  task automatic step(input in_t v, input string tag);
    logic [7:0] e0, e1;
    @(negedge clk);
    drive(v);
    if (!v.rst) mreset();
    #2;
    e0 = mexp(0, v);
    e1 = mexp(1, v);
    chk({tag, "/out0"}, 64'(outs(0)), 64'(e0));
    chk({tag, "/out1"}, 64'(outs(1)), 64'(e1));
    chk({tag, "/cnt0"}, 64'(cnt0), 64'(mcnt[0]));
    chk({tag, "/cnt1"}, 64'(cnt1), 64'(mcnt[1]));
    mtick(v, e0, e1);
  endtask

  task automatic do_reset();
    in_t v = idle();
    v.rst = 1'b0;
    step(v, "rst");
  endtask

  function automatic in_t lu_vec(logic [4:0] rd);
    in_t v = idle();
    v.exv = 1; v.ld = 1; v.exrd = rd;
    v.rs2 = rd; v.rs2u = 1;
    return v;
  endfunction

  vec_t tab[12];
  in_t  v;

  initial begin
    drive(idle());
    rst = 1'b0;
    mreset();

    // reset state
    do_reset();
    chk("rst_pattern", 64'(outs(0)), 64'h0E);

    // single-cycle combinational table, applied in RUN
    tab[0].i = idle();
    tab[0].e = 8'b0000_0000;
    tab[1].i = idle(); tab[1].i.ifu = 0;
    tab[1].e = 8'b1000_1000;
    tab[2].i = lu_vec(5);
    tab[2].e = 8'b1100_0100;
    tab[3].i = lu_vec(0);
    tab[3].e = 8'b0000_0000;
    tab[4].i = lu_vec(5); tab[4].i.redir = 1;
    tab[4].e = 8'b0000_1100;
    tab[5].i = lu_vec(7); tab[5].i.rs2u = 0;
    tab[5].i.rs1 = 7;
    tab[5].e = 8'b0000_0000;
    tab[6].i = lu_vec(7); tab[6].i.ld = 0;
    tab[6].e = 8'b0000_0000;
    tab[7].i = lu_vec(7); tab[7].i.exv = 0;
    tab[7].e = 8'b0000_0000;
    tab[8].i = idle(); tab[8].i.req = 1;
    tab[8].e = 8'b1111_0010;
    tab[9].i = idle(); tab[9].i.req = 1;
    tab[9].i.ack = 1;
    tab[9].e = 8'b0000_0000;
    tab[10].i = tab[8].i; tab[10].i.redir = 1;
    tab[10].e = 8'b1111_0010;
    tab[11].i = lu_vec(9); tab[11].i.ifu = 0;
    tab[11].i.rs2u = 0; tab[11].i.rs1 = 9;
    tab[11].i.rs1u = 1;
    tab[11].e = 8'b1100_0100;

    step(idle(), "idle");
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      drive(tab[k].i);
      #2;
      chk($sformatf("tab%0d/d0", k),
          64'(outs(0)), 64'(tab[k].e));
      chk($sformatf("tab%0d/d1", k),
          64'(outs(1)), 64'(tab[k].e));
      #1;
      drive(idle());
    end

    // load-use: one bubble, then the load leaves EX
    step(lu_vec(5), "lu1");
    v = lu_vec(5); v.exv = 0;
    step(v, "lu2");
    chk("lu_released", 64'(outs(0)), 64'h00);
    step(lu_vec(0), "lu_x0");

    // memory wait: three miss cycles then ack
    do_reset();
    v = idle(); v.req = 1;
    for (int k = 0; k < 3; k++) step(v, "mw");
    v.ack = 1;
    step(v, "mw_ack");
    chk("mw_ack_out", 64'(outs(0)), 64'h00);
    step(idle(), "mw_done");
    chk("mw_cnt", 64'(cnt0), 64'd3);

    // zero-wait access
    v = idle(); v.req = 1; v.ack = 1;
    step(v, "zw");
    step(idle(), "zw2");
    chk("zw_cnt", 64'(cnt0), 64'd3);

    // redirect held off during a miss
    do_reset();
    v = idle(); v.req = 1;
    step(v, "rd_mw0");
    v.redir = 1;
    step(v, "rd_mw1");
    chk("rd_frozen", 64'(outs(0)), 64'hF2);
    v.ack = 1;
    step(v, "rd_ack");
    chk("rd_ack_out", 64'(outs(0)), 64'h0C);

    // watchdog: four unacked wait cycles
    do_reset();
    v = idle(); v.req = 1;
    for (int k = 0; k < 5; k++) step(v, "wd");
    step(v, "wd_err");
    chk("wd_tmo1", 64'(tmo[1]), 64'd1);
    chk("wd_tmo0", 64'(tmo[0]), 64'd0);
    step(idle(), "wd_abs");
    chk("wd_stall", 64'(sif[1]), 64'd1);

    // watchdog: ack on the last allowed cycle
    do_reset();
    v = idle(); v.req = 1;
    for (int k = 0; k < 4; k++) step(v, "wa");
    v.ack = 1;
    step(v, "wa_ack");
    step(idle(), "wa_run");
    chk("wa_tmo1", 64'(tmo[1]), 64'd0);
    chk("wa_out1", 64'(outs(1)), 64'h00);

    // asynchronous reset in the middle of a wait
    do_reset();
    v = idle(); v.req = 1;
    step(v, "ar0");
    step(v, "ar1");
    @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("ar_out0", 64'(outs(0)), 64'h0E);
    chk("ar_out1", 64'(outs(1)), 64'h0E);
    chk("ar_cnt0", 64'(cnt0), 64'd0);
    chk("ar_cnt1", 64'(cnt1), 64'd0);
    mreset();
    step(idle(), "ar_run");
    chk("ar_run0", 64'(outs(0)), 64'h00);

    // counter saturation on the narrow instance
    do_reset();
    v = idle(); v.ifu = 0;
    for (int k = 0; k < 20; k++) step(v, "sat");
    step(idle(), "sat_end");
    chk("sat_cnt1", 64'(cnt1), 64'd15);
    chk("sat_cnt0", 64'(cnt0), 64'd20);

    // randomized traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      v = idle();
      v.rst   = ($urandom_range(0, 63) != 0);
      v.rs1   = 5'($urandom_range(0, 3));
      v.rs2   = 5'($urandom_range(0, 3));
      v.exrd  = 5'($urandom_range(0, 3));
      v.rs1u  = 1'($urandom_range(0, 1));
      v.rs2u  = 1'($urandom_range(0, 1));
      v.ld    = 1'($urandom_range(0, 1));
      v.exv   = ($urandom_range(0, 3) != 0);
      v.req   = ($urandom_range(0, 2) == 0);
      v.ack   = 1'($urandom_range(0, 1));
      v.redir = ($urandom_range(0, 5) == 0);
      v.ifu   = ($urandom_range(0, 5) != 0);
      step(v, "rnd");
    end

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
